shot_clock_ctrl: RTL and testbench



---
 rtl/shot_clock_ctrl_pkg.sv | 30 +++
 rtl/shot_clock_ctrl_bcd_down2.sv | 44 ++++
 rtl/shot_clock_ctrl.sv | 138 +++++++++++++
 tb/tb_shot_clock_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_clock_ctrl_pkg.sv
// Shared scoreboard definitions: shot-clock state encoding, default reload values
// and the scan-rate tick frequency also used by the display scanner.
package shot_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StPause   = 2'd2,
        StExpired = 2'd3
    } sc_state_e;

    // Scan-rate strobe frequency (ticks per second).
    localparam int unsigned TickRateHz = 1000;

    localparam int unsigned FullSecDefault  = 24;
    localparam int unsigned ShortSecDefault = 14;

    localparam logic [7:0] FullSecBcd  = 8'h24;
    localparam logic [7:0] ShortSecBcd = 8'h14;

    // Two-digit BCD encoding of a value 0..99.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 10) % 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/shot_clock_ctrl_bcd_down2.sv
// Two-digit BCD down-counter with synchronous load; holds at 00.
module bcd_down2 import shot_clock_ctrl_pkg::*; #(
    parameter logic [7:0] RESET_VAL = FullSecBcd
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       zero_o
);

    logic [7:0] val_q, val_d;

    // Digit register with synchronous reset to the reload value.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= RESET_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    // Load has priority; decrement borrows from tens when ones is 0.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (dec_i && (val_q != 8'h00)) begin
            if (val_q[3:0] == 4'd0) begin
                val_d = {val_q[7:4] - 4'd1, 4'd9};
            end else begin
                val_d = {val_q[7:4], val_q[3:0] - 4'd1};
            end
        end
    end

    assign tens_o = val_q[7:4];
    assign ones_o = val_q[3:0];
    assign zero_o = (val_q == 8'h00);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: divides the scan-rate tick into seconds, runs the
// idle/run/pause/expired FSM, drives the BCD countdown and the buzzer enable.
module shot_clock_ctrl import shot_clock_ctrl_pkg::*; #(
    parameter int unsigned TICKS_PER_SEC = TickRateHz,
    parameter int unsigned FULL_SEC      = FullSecDefault,
    parameter int unsigned SHORT_SEC     = ShortSecDefault,
    parameter int unsigned BUZZ_SEC      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_i,
    input  logic       btn_start_i,
    input  logic       btn_pause_i,
    input  logic       btn_rst24_i,
    input  logic       btn_rst14_i,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running_o,
    output logic       expired_o,
    output logic       buzzer_o
);

    localparam int unsigned SubW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned BuzzTicks = BUZZ_SEC * TICKS_PER_SEC;
    localparam int unsigned BuzzW     = $clog2(BuzzTicks + 1);

    localparam logic [SubW-1:0]  SubLast  = SubW'(TICKS_PER_SEC - 1);
    localparam logic [BuzzW-1:0] BuzzLast = BuzzW'(BuzzTicks - 1);
    localparam logic [7:0]       FullBcd  = to_bcd2(FULL_SEC);
    localparam logic [7:0]       ShortBcd = to_bcd2(SHORT_SEC);

    sc_state_e        state_q, state_d;
    logic [SubW-1:0]  sub_q, sub_d;
    logic [BuzzW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic             buzz_q, buzz_d;

    logic       load;
    logic [7:0] load_val;
    logic       dec;
    logic       val_zero;
    logic [7:0] value;
    logic       rst14_ok;

    assign value    = {sec_tens_o, sec_ones_o};
    // rst14 is a no-op unless the clock is already below the short value.
    assign rst14_ok = btn_rst14_i && (value < ShortBcd);

    bcd_down2 #(
        .RESET_VAL (FullBcd)
    ) u_bcd (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .dec_i      (dec),
        .tens_o     (sec_tens_o),
        .ones_o     (sec_ones_o),
        .zero_o     (val_zero)
    );

    // State, sub-second phase and buzzer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sub_q      <= '0;
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    // Next-state: reloads beat pause beat start; any acting button swallows a tick.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        buzz_cnt_d = buzz_cnt_q;
        buzz_d     = buzz_q;
        load       = 1'b0;
        load_val   = FullBcd;
        dec        = 1'b0;

        if (btn_rst24_i || rst14_ok) begin
            load     = 1'b1;
            load_val = btn_rst24_i ? FullBcd : ShortBcd;
            sub_d    = '0;
            if (state_q == StExpired) begin
                state_d    = StIdle;
                buzz_d     = 1'b0;
                buzz_cnt_d = '0;
            end
        end else if (btn_pause_i) begin
            if (state_q == StRun) begin
                state_d = StPause;
            end
        end else if (btn_start_i) begin
            if (state_q == StIdle) begin
                state_d = StRun;
                sub_d   = '0;
            end else if (state_q == StPause) begin
                state_d = StRun;
            end
        end else if (tick_i) begin
            unique case (state_q)
                StRun: begin
                    if (sub_q == SubLast) begin
                        sub_d = '0;
                        dec   = !val_zero;
                        if (value == 8'h01) begin
                            state_d    = StExpired;
                            buzz_d     = 1'b1;
                            buzz_cnt_d = '0;
                        end
                    end else begin
                        sub_d = sub_q + SubW'(1);
                    end
                end
                StExpired: begin
                    if (buzz_q) begin
                        buzz_cnt_d = buzz_cnt_q + BuzzW'(1);
                        if (buzz_cnt_q == BuzzLast) begin
                            buzz_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign running_o = (state_q == StRun);
    assign expired_o = (state_q == StExpired);
    assign buzzer_o  = buzz_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with 4 ticks/second and a 1-second buzzer.
module tb_shot_clock_ctrl;

    logic       clk;
    logic       rst;
    logic       tick_i;
    logic       btn_start_i;
    logic       btn_pause_i;
    logic       btn_rst24_i;
    logic       btn_rst14_i;
    logic [3:0] sec_tens_o;
    logic [3:0] sec_ones_o;
    logic       running_o;
    logic       expired_o;
    logic       buzzer_o;

    logic [7:0] digits;
    logic [2:0] flags;   // {running, expired, buzzer}

    int n_vec;
    int n_err;

    assign digits = {sec_tens_o, sec_ones_o};
    assign flags  = {running_o, expired_o, buzzer_o};

    shot_clock_ctrl #(
        .TICKS_PER_SEC (4),
        .FULL_SEC      (24),
        .SHORT_SEC     (14),
        .BUZZ_SEC      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_i),
        .btn_start_i (btn_start_i),
        .btn_pause_i (btn_pause_i),
        .btn_rst24_i (btn_rst24_i),
        .btn_rst14_i (btn_rst14_i),
        .sec_tens_o  (sec_tens_o),
        .sec_ones_o  (sec_ones_o),
        .running_o   (running_o),
        .expired_o   (expired_o),
        .buzzer_o    (buzzer_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic t, input logic s, input logic p,
                        input logic r24, input logic r14, input logic r);
        tick_i      = t;
        btn_start_i = s;
        btn_pause_i = p;
        btn_rst24_i = r24;
        btn_rst14_i = r14;
        rst         = r;
        @(posedge clk);
        #1;
        tick_i      = 1'b0;
        btn_start_i = 1'b0;
        btn_pause_i = 1'b0;
        btn_rst24_i = 1'b0;
        btn_rst14_i = 1'b0;
        rst         = 1'b0;
    endtask

    // n ticks, each followed by two quiet cycles (tick every 3rd cycle).
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (digits !== 8'h24) begin
            n_err++; $display("FAIL reset_digits: got %h want 24", digits);
        end
        n_vec++;
        if (flags !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: got %b want 000", flags);
        end
    endtask

    task automatic test_start;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (flags !== 3'b100) begin
            n_err++; $display("FAIL start_running: got %b want 100", flags);
        end
        ticks(3);
        n_vec++;
        if (digits !== 8'h24) begin
            n_err++; $display("FAIL start_3ticks: got %h want 24", digits);
        end
        ticks(1);
        n_vec++;
        if (digits !== 8'h23) begin
            n_err++; $display("FAIL start_first_dec: got %h want 23", digits);
        end
    endtask

    task automatic test_borrow_expire;
        ticks(52);
        n_vec++;
        if (digits !== 8'h10) begin
            n_err++; $display("FAIL run_to_10: got %h want 10", digits);
        end
        ticks(4);
        n_vec++;
        if (digits !== 8'h09) begin
            n_err++; $display("FAIL borrow: got %h want 09", digits);
        end
        ticks(35);
        n_vec++;
        if (digits !== 8'h01 || flags !== 3'b100) begin
            n_err++; $display("FAIL at_01: got %h/%b want 01/100", digits, flags);
        end
        ticks(1);
        n_vec++;
        if (digits !== 8'h00 || flags !== 3'b011) begin
            n_err++; $display("FAIL expire_edge: got %h/%b want 00/011", digits, flags);
        end
        ticks(3);
        n_vec++;
        if (flags !== 3'b011) begin
            n_err++; $display("FAIL buzz_3ticks: got %b want 011", flags);
        end
        ticks(1);
        n_vec++;
        if (flags !== 3'b010) begin
            n_err++; $display("FAIL buzz_drop: got %b want 010", flags);
        end
        ticks(2);
        n_vec++;
        if (digits !== 8'h00 || flags !== 3'b010) begin
            n_err++; $display("FAIL expired_hold: got %h/%b want 00/010", digits, flags);
        end
    endtask

    task automatic test_rst14;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(24);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (digits !== 8'h18 || flags !== 3'b100) begin
            n_err++; $display("FAIL rst14_at_18: got %h/%b want 18/100", digits, flags);
        end
        ticks(36);
        n_vec++;
        if (digits !== 8'h09) begin
            n_err++; $display("FAIL run_to_09: got %h want 09", digits);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (digits !== 8'h14 || flags !== 3'b100) begin
            n_err++; $display("FAIL rst14_at_09: got %h/%b want 14/100", digits, flags);
        end
        ticks(57);
        n_vec++;
        if (digits !== 8'h00 || flags !== 3'b011) begin
            n_err++; $display("FAIL expire_from_14: got %h/%b want 00/011", digits, flags);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (digits !== 8'h14 || flags !== 3'b000) begin
            n_err++; $display("FAIL rst14_expired: got %h/%b want 14/000", digits, flags);
        end
    endtask

    task automatic test_pause_phase;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (digits !== 8'h14 || flags !== 3'b000) begin
            n_err++; $display("FAIL pause_enter: got %h/%b want 14/000", digits, flags);
        end
        ticks(10);
        n_vec++;
        if (digits !== 8'h14 || flags !== 3'b000) begin
            n_err++; $display("FAIL pause_hold: got %h/%b want 14/000", digits, flags);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        n_vec++;
        if (digits !== 8'h14 || flags !== 3'b100) begin
            n_err++; $display("FAIL resume_1tick: got %h/%b want 14/100", digits, flags);
        end
        ticks(1);
        n_vec++;
        if (digits !== 8'h13) begin
            n_err++; $display("FAIL resume_phase: got %h want 13", digits);
        end
    endtask

    task automatic test_coincide;
        ticks(1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (digits !== 8'h24 || flags !== 3'b100) begin
            n_err++; $display("FAIL rst24_pause: got %h/%b want 24/100", digits, flags);
        end
        ticks(3);
        n_vec++;
        if (digits !== 8'h24) begin
            n_err++; $display("FAIL rst24_sub_clear_a: got %h want 24", digits);
        end
        ticks(1);
        n_vec++;
        if (digits !== 8'h23) begin
            n_err++; $display("FAIL rst24_sub_clear_b: got %h want 23", digits);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (flags !== 3'b000) begin
            n_err++; $display("FAIL start_pause: got %b want 000", flags);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (flags !== 3'b100) begin
            n_err++; $display("FAIL tick_start_resume: got %b want 100", flags);
        end
        ticks(3);
        n_vec++;
        if (digits !== 8'h23) begin
            n_err++; $display("FAIL tick_swallowed_a: got %h want 23", digits);
        end
        ticks(1);
        n_vec++;
        if (digits !== 8'h22) begin
            n_err++; $display("FAIL tick_swallowed_b: got %h want 22", digits);
        end
    endtask

    task automatic test_rst_mid_buzz;
        ticks(88);
        n_vec++;
        if (digits !== 8'h00 || flags !== 3'b011) begin
            n_err++; $display("FAIL expire_from_22: got %h/%b want 00/011", digits, flags);
        end
        ticks(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (digits !== 8'h24 || flags !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_buzz: got %h/%b want 24/000", digits, flags);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (flags !== 3'b000) begin
            n_err++; $display("FAIL pause_in_idle: got %b want 000", flags);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (flags !== 3'b100) begin
            n_err++; $display("FAIL start_after_rst: got %b want 100", flags);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        tick_i      = 1'b0;
        btn_start_i = 1'b0;
        btn_pause_i = 1'b0;
        btn_rst24_i = 1'b0;
        btn_rst14_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_start();
        test_borrow_expire();
        test_rst14();
        test_pause_phase();
        test_coincide();
        test_rst_mid_buzz();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
